// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the execute stage (master) and dmem_ctrl (slave).
// DATA_W and ADDR_W must match the parameters of the attached dmem_ctrl.
interface dmem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) ();
    localparam int OFF = $clog2(DATA_W / 8);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W+OFF-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_sext;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_sext, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_sext, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding data-memory controller with byte-lane steering,
// sign/zero extension and LAT wait states between accept and response.
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   -> misaligned or oversized accesses complete with resp_err=1, no access
//   undefined -> size clamped to the word, address rounded down to alignment, resp_err=0
module dmem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LAT    = 1
) (
    input  logic      clk,
    input  logic      rstd,
    dmem_ctrl_if.slave bus
);
    localparam int OFF = $clog2(DATA_W / 8);
    localparam int NB  = DATA_W / 8;
    localparam logic [3:0] CNT_INIT = (LAT > 32'sd0) ? 4'(LAT - 32'sd1) : 4'd0;
    localparam bit LAT_ZERO = (LAT == 32'sd0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bits below the alignment boundary of a 2**size-byte access.
    function automatic logic [OFF-1:0] low_mask(input logic [1:0] size);
        logic [OFF-1:0] m;
        for (int i = 0; i < OFF; i++) begin
            m[i] = (i < int'(size));
        end
        return m;
    endfunction

    // Active-low lane write mask covering lanes lane .. lane+2**size-1.
    function automatic logic [NB-1:0] lane_mask_n(input logic [OFF-1:0] lane, input logic [1:0] size);
        logic [NB-1:0] m;
        int lo;
        int hi;
        lo = int'(lane);
        hi = lo + (32'sd1 << size);
        for (int b = 0; b < NB; b++) begin
            m[b] = !((b >= lo) && (b < hi));
        end
        return m;
    endfunction

    // Pick the addressed lanes, right-justify them and extend to the full word.
    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                       input logic [OFF-1:0] lane,
                                                       input logic [1:0] size,
                                                       input logic sext);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        logic              sign;
        int                nb;
        sh   = word >> {lane, 3'b000};
        nb   = 32'sd1 << size;
        sign = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (b == nb - 32'sd1) begin
                sign = sh[b*8+7];
            end else begin
                sign = sign;
            end
        end
        sign = sign & sext;
        for (int b = 0; b < NB; b++) begin
            if (b < nb) begin
                res[b*8 +: 8] = sh[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = {8{sign}};
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0]     mem [2**ADDR_W];

    state_t                state_r;
    logic [3:0]            cnt_r;
    logic                  cap_we_r;
    logic [ADDR_W+OFF-1:0] cap_addr_r;
    logic [1:0]            cap_size_r;
    logic                  cap_sext_r;
    logic [DATA_W-1:0]     cap_wdata_r;
    logic                  resp_valid_r;
    logic [DATA_W-1:0]     resp_rdata_r;
    logic                  resp_err_r;

    logic                  ready_s;
    logic                  accept_s;
    logic                  enter_rsp_s;
    logic                  src_we_s;
    logic [ADDR_W+OFF-1:0] src_addr_s;
    logic [1:0]            src_size_s;
    logic                  src_sext_s;
    logic [DATA_W-1:0]     src_wdata_s;
    logic [ADDR_W-1:0]     word_s;
    logic [OFF-1:0]        lane_s;
    logic [1:0]            size_s;
    logic                  err_s;
    logic                  mem_we_s;
    logic [NB-1:0]         wmask_n_s;
    logic [DATA_W-1:0]     wshift_s;

    assign ready_s  = (state_r == ST_IDLE) && !rstd;
    assign accept_s = bus.req_valid && ready_s;

    // Access source: live request when entering RESP straight from IDLE (LAT=0), else the captured one.
    always_comb begin
        src_we_s    = cap_we_r;
        src_addr_s  = cap_addr_r;
        src_size_s  = cap_size_r;
        src_sext_s  = cap_sext_r;
        src_wdata_s = cap_wdata_r;
        if (state_r == ST_IDLE) begin
            src_we_s    = bus.req_we;
            src_addr_s  = bus.req_addr;
            src_size_s  = bus.req_size;
            src_sext_s  = bus.req_sext;
            src_wdata_s = bus.req_wdata;
        end else begin
            src_we_s    = cap_we_r;
        end
    end

    // Address decode, alignment handling and lane steering for the pending access.
    always_comb begin
        word_s = src_addr_s[ADDR_W+OFF-1:OFF];
`ifdef DMEM_ALIGN_CHECK_EN
        size_s = src_size_s;
        lane_s = src_addr_s[OFF-1:0];
        err_s  = (src_size_s > 2'(OFF)) || ((src_addr_s[OFF-1:0] & low_mask(src_size_s)) != '0);
`else
        if (src_size_s > 2'(OFF)) begin
            size_s = 2'(OFF);
        end else begin
            size_s = src_size_s;
        end
        lane_s = src_addr_s[OFF-1:0] & ~low_mask(size_s);
        err_s  = 1'b0;
`endif
        wmask_n_s = lane_mask_n(lane_s, size_s);
        wshift_s  = src_wdata_s << {lane_s, 3'b000};
    end

    // Edge that moves the FSM into RESP is the one that touches the array.
    always_comb begin
        if (state_r == ST_IDLE) begin
            enter_rsp_s = accept_s && LAT_ZERO;
        end else begin
            enter_rsp_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
        end
        mem_we_s = enter_rsp_s && !rstd && src_we_s && !err_s;
    end

    // Byte-lane array writes; contents intentionally left unreset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < NB; b++) begin
                if (!wmask_n_s[b]) begin
                    mem[word_s][b*8 +: 8] <= wshift_s[b*8 +: 8];
                end
            end
        end
    end

    // Control FSM, request capture and registered one-cycle response.
    always_ff @(posedge clk) begin
        if (rstd) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            cap_we_r     <= 1'b0;
            cap_addr_r   <= '0;
            cap_size_r   <= 2'd0;
            cap_sext_r   <= 1'b0;
            cap_wdata_r  <= '0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
        end else begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cap_we_r    <= bus.req_we;
                        cap_addr_r  <= bus.req_addr;
                        cap_size_r  <= bus.req_size;
                        cap_sext_r  <= bus.req_sext;
                        cap_wdata_r <= bus.req_wdata;
                        if (LAT_ZERO) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            if (enter_rsp_s) begin
                resp_valid_r <= 1'b1;
                resp_err_r   <= err_s;
                if (src_we_s || err_s) begin
                    resp_rdata_r <= '0;
                end else begin
                    resp_rdata_r <= load_extract(mem[word_s], lane_s, size_s, src_sext_s);
                end
            end
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a 32-bit LAT=2 instance driven from a vector
// table plus reset-abort sequences, and a 64-bit LAT=0 instance for back-to-back use.
module tb_dmem_ctrl;
    localparam int LAT32 = 2;
    localparam int NV    = 16;

    logic clk;
    logic rstd;

    dmem_ctrl_if #(.DATA_W(32), .ADDR_W(8)) b32 ();
    dmem_ctrl_if #(.DATA_W(64), .ADDR_W(8)) b64 ();

    dmem_ctrl #(.DATA_W(32), .ADDR_W(8), .LAT(LAT32)) u_dut32 (.clk(clk), .rstd(rstd), .bus(b32));
    dmem_ctrl #(.DATA_W(64), .ADDR_W(8), .LAT(0))     u_dut64 (.clk(clk), .rstd(rstd), .bus(b64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vec [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic we, input logic [9:0] addr, input logic [1:0] size,
                                input logic sext, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.sext = sext;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One access on the 32-bit instance with per-cycle checks of the handshake timing.
    task automatic acc32(input logic we, input logic [9:0] addr, input logic [1:0] size,
                         input logic sext, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
        int n;
        rd = 32'h0;
        er = 1'b0;
        @(negedge clk);
        b32.req_valid = 1'b1; b32.req_we = we; b32.req_addr = addr;
        b32.req_size = size; b32.req_sext = sext; b32.req_wdata = wdata;
        n = 0;
        while (!b32.req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 64'(b32.req_ready), 64'd1);
        @(posedge clk);
        #1;
        b32.req_valid = 1'b0; b32.req_we = !we; b32.req_addr = ~addr;
        b32.req_size = ~size; b32.req_sext = !sext; b32.req_wdata = ~wdata;
        for (int k = 1; k <= LAT32 + 2; k++) begin
            @(negedge clk);
            check($sformatf("resp_valid_c%0d", k), 64'(b32.resp_valid), 64'(k == LAT32 + 1));
            check($sformatf("req_ready_c%0d", k), 64'(b32.req_ready), 64'(k == LAT32 + 2));
            if (k == LAT32 + 1) begin
                rd = b32.resp_rdata;
                er = b32.resp_err;
            end
        end
    endtask

    // Abort a store byte 0x55 @0x30 with rstd high at the given edge after accept (1 = in WAIT).
    task automatic abort32(input int rst_edge);
        @(negedge clk);
        b32.req_valid = 1'b1; b32.req_we = 1'b1; b32.req_addr = 10'h030;
        b32.req_size = 2'd0; b32.req_sext = 1'b0; b32.req_wdata = 32'h0000_0055;
        check("abort_ready", 64'(b32.req_ready), 64'd1);
        @(posedge clk);
        for (int e = 1; e < rst_edge; e++) begin
            #1 b32.req_valid = 1'b0;
            @(posedge clk);
        end
        #1 b32.req_valid = 1'b0;
        rstd = 1'b1;
        @(negedge clk);
        check("abort_ready_in_reset", 64'(b32.req_ready), 64'd0);
        @(posedge clk);
        #1 rstd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("abort_no_resp_%0d", k), 64'(b32.resp_valid), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;

        vec[0]  = mk(1'b1, 10'h010, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        vec[1]  = mk(1'b0, 10'h010, 2'd2, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        vec[2]  = mk(1'b1, 10'h020, 2'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
        vec[3]  = mk(1'b1, 10'h021, 2'd0, 1'b0, 32'hCAFE_BA80, 32'h0000_0000, 1'b0);
        vec[4]  = mk(1'b0, 10'h021, 2'd0, 1'b1, 32'h0000_0000, 32'hFFFF_FF80, 1'b0);
        vec[5]  = mk(1'b0, 10'h021, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0080, 1'b0);
        vec[6]  = mk(1'b0, 10'h020, 2'd2, 1'b0, 32'h0000_0000, 32'h0000_8000, 1'b0);
        vec[7]  = mk(1'b1, 10'h020, 2'd2, 1'b0, 32'hAAAA_AAAA, 32'h0000_0000, 1'b0);
        vec[8]  = mk(1'b1, 10'h022, 2'd1, 1'b0, 32'hFFFF_1234, 32'h0000_0000, 1'b0);
        vec[9]  = mk(1'b0, 10'h020, 2'd2, 1'b0, 32'h0000_0000, 32'h1234_AAAA, 1'b0);
        vec[10] = mk(1'b0, 10'h022, 2'd1, 1'b1, 32'h0000_0000, 32'h0000_1234, 1'b0);
        vec[11] = mk(1'b0, 10'h020, 2'd1, 1'b1, 32'h0000_0000, 32'hFFFF_AAAA, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        vec[12] = mk(1'b0, 10'h023, 2'd1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1);
        vec[13] = mk(1'b1, 10'h021, 2'd2, 1'b0, 32'h9999_9999, 32'h0000_0000, 1'b1);
        vec[14] = mk(1'b0, 10'h020, 2'd2, 1'b0, 32'h0000_0000, 32'h1234_AAAA, 1'b0);
        vec[15] = mk(1'b0, 10'h020, 2'd3, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1);
`else
        vec[12] = mk(1'b0, 10'h023, 2'd1, 1'b0, 32'h0000_0000, 32'h0000_1234, 1'b0);
        vec[13] = mk(1'b1, 10'h021, 2'd2, 1'b0, 32'h9999_9999, 32'h0000_0000, 1'b0);
        vec[14] = mk(1'b0, 10'h020, 2'd2, 1'b0, 32'h0000_0000, 32'h9999_9999, 1'b0);
        vec[15] = mk(1'b0, 10'h020, 2'd3, 1'b0, 32'h0000_0000, 32'h9999_9999, 1'b0);
`endif

        rstd = 1'b1;
        b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_addr = 10'h0;
        b32.req_size = 2'd0; b32.req_sext = 1'b0; b32.req_wdata = 32'h0;
        b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_addr = 11'h0;
        b64.req_size = 2'd0; b64.req_sext = 1'b0; b64.req_wdata = 64'h0;
        repeat (3) @(posedge clk);

        // Reset state while rstd is held high.
        @(negedge clk);
        check("rst_ready", 64'(b32.req_ready), 64'd0);
        check("rst_resp_valid", 64'(b32.resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(b32.resp_rdata), 64'd0);
        check("rst_resp_err", 64'(b32.resp_err), 64'd0);
        check("rst_ready64", 64'(b64.req_ready), 64'd0);
        rstd = 1'b0;
        @(negedge clk);
        check("ready_after_release", 64'(b32.req_ready), 64'd1);
        check("resp_valid_after_release", 64'(b32.resp_valid), 64'd0);

        // Table-driven accesses on the 32-bit instance.
        for (int i = 0; i < NV; i++) begin
            acc32(vec[i].we, vec[i].addr, vec[i].size, vec[i].sext, vec[i].wdata, rd, er);
            check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vec[i].exp_rdata));
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vec[i].exp_err));
        end

        // Reset during WAIT and at the edge that would enter RESP: no write, no response.
        acc32(1'b1, 10'h030, 2'd0, 1'b0, 32'h0000_0011, rd, er);
        abort32(1);
        abort32(LAT32);
        acc32(1'b0, 10'h030, 2'd0, 1'b0, 32'h0, rd, er);
        check("abort_byte_kept", 64'(rd), 64'h11);
        check("abort_byte_err", 64'(er), 64'd0);

        // 64-bit LAT=0 instance: req_valid held high, accept on every second edge.
        @(negedge clk);
        b64.req_valid = 1'b1; b64.req_we = 1'b1; b64.req_addr = 11'h008;
        b64.req_size = 2'd3; b64.req_sext = 1'b0; b64.req_wdata = 64'h0123_4567_89AB_CDEF;
        check("b2b_ready0", 64'(b64.req_ready), 64'd1);
        @(negedge clk);
        check("b2b_st_valid", 64'(b64.resp_valid), 64'd1);
        check("b2b_st_rdata", b64.resp_rdata, 64'd0);
        check("b2b_st_err", 64'(b64.resp_err), 64'd0);
        check("b2b_busy1", 64'(b64.req_ready), 64'd0);
        b64.req_we = 1'b0; b64.req_wdata = 64'h0;
        @(negedge clk);
        check("b2b_ready1", 64'(b64.req_ready), 64'd1);
        check("b2b_gap1", 64'(b64.resp_valid), 64'd0);
        @(negedge clk);
        check("b2b_ld_valid", 64'(b64.resp_valid), 64'd1);
        check("b2b_ld_dword", b64.resp_rdata, 64'h0123_4567_89AB_CDEF);
        b64.req_addr = 11'h00F; b64.req_size = 2'd0; b64.req_sext = 1'b1;
        @(negedge clk);
        check("b2b_gap2", 64'(b64.resp_valid), 64'd0);
        @(negedge clk);
        check("b2b_ld_byte7", b64.resp_rdata, 64'h0000_0000_0000_0001);
        b64.req_addr = 11'h00A; b64.req_size = 2'd1; b64.req_sext = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_ld_half_sext", b64.resp_rdata, 64'hFFFF_FFFF_FFFF_89AB);
        b64.req_addr = 11'h00C; b64.req_size = 2'd2; b64.req_sext = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_ld_word_hi", b64.resp_rdata, 64'h0000_0000_0123_4567);
        b64.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle_no_resp", 64'(b64.resp_valid), 64'd0);
        check("b2b_idle_ready", 64'(b64.req_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
